// File: rtl/vector_checker.sv
// Hardware vector checker: walks a vector store, drives stimulus into a DUT and
// compares its masked response after LAT cycles, reporting error statistics.
module vector_checker #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 19,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned LAT   = 0,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned VEC_W  = 1 + IN_W + 2 * OUT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [VEC_W-1:0]  vec_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic              first_err_valid,
  output logic [ADDR_W:0]   applied_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic              valid;
    logic [OUT_W-1:0]  exp;
    logic [OUT_W-1:0]  mask;
    logic [ADDR_W-1:0] idx;
  } flight_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_idx_q, first_err_idx_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic [CNT_W-1:0]  applied_count_q, applied_count_d;
  logic              drained_q, drained_d;
  flight_t           pipe_q [LAT+1];
  flight_t           pipe_d [LAT+1];

  logic              vec_valid_c;
  logic [IN_W-1:0]   vec_stim_c;
  logic [OUT_W-1:0]  vec_exp_c;
  logic [OUT_W-1:0]  vec_mask_c;
  logic              in_flight_c;
  logic              mismatch_c;

  assign vec_valid_c = vec_data[VEC_W-1];
  assign vec_stim_c  = vec_data[VEC_W-2 -: IN_W];
  assign vec_exp_c   = vec_data[2*OUT_W-1 -: OUT_W];
  assign vec_mask_c  = vec_data[OUT_W-1:0];

  // Any compare still travelling through the latency-matching delay line.
  always_comb begin
    in_flight_c = 1'b0;
    for (int i = 0; i <= int'(LAT); i++) begin
      in_flight_c = in_flight_c | pipe_q[i].valid;
    end
  end

  assign mismatch_c = pipe_q[LAT].valid &&
                      (|((dut_out ^ pipe_q[LAT].exp) & pipe_q[LAT].mask));

  always_comb begin
    state_d           = state_q;
    vec_addr_d        = vec_addr_q;
    dut_in_d          = dut_in_q;
    err_count_d       = err_count_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_valid_d = first_err_valid_q;
    applied_count_d   = applied_count_q;
    drained_d         = 1'b0;
    pipe_d[0]         = '0;
    for (int i = 1; i <= int'(LAT); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (mismatch_c) begin
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
      if (!first_err_valid_q) begin
        first_err_idx_d   = pipe_q[LAT].idx;
        first_err_valid_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d           = RUN;
          vec_addr_d        = '0;
          err_count_d       = '0;
          first_err_idx_d   = '0;
          first_err_valid_d = 1'b0;
          applied_count_d   = '0;
        end
      end
      RUN: begin
        if (vec_valid_c) begin
          dut_in_d        = vec_stim_c;
          pipe_d[0]       = '{valid: 1'b1, exp: vec_exp_c, mask: vec_mask_c, idx: vec_addr_q};
          applied_count_d = applied_count_q + CNT_W'(1);
          if (vec_addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            vec_addr_d = vec_addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // One settle cycle after the last retire so counters are stable before done.
        if (!in_flight_c) begin
          drained_d = 1'b1;
          if (drained_q) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_count_d == 16'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      vec_addr_q        <= '0;
      dut_in_q          <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
      applied_count_q   <= '0;
      drained_q         <= 1'b0;
      pipe_q            <= '{default: '0};
    end else begin
      state_q           <= state_d;
      vec_addr_q        <= vec_addr_d;
      dut_in_q          <= dut_in_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      err_count_q       <= err_count_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_valid_q <= first_err_valid_d;
      applied_count_q   <= applied_count_d;
      drained_q         <= drained_d;
      pipe_q            <= pipe_d;
    end
  end

  assign vec_addr        = vec_addr_q;
  assign dut_in          = dut_in_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_valid = first_err_valid_q;
  assign applied_count   = applied_count_q;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker: a combinational DUT (LAT=0) and a
// two-stage registered DUT (LAT=2), each fed from its own vector store.
module tb_vector_checker;

  localparam int unsigned IN_W  = 12;
  localparam int unsigned OUT_W = 19;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned VEC_W = 1 + IN_W + 2 * OUT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a_n, rst_b_n, start_a, start_b;
  logic [AW-1:0]     vec_addr_a, vec_addr_b, fei_a, fei_b;
  logic [VEC_W-1:0]  vec_data_a, vec_data_b;
  logic [IN_W-1:0]   dut_in_a, dut_in_b;
  logic [OUT_W-1:0]  dut_out_a, dut_out_b, p1_b, p2_b;
  logic              busy_a, busy_b, done_a, done_b, pass_a, pass_b, fev_a, fev_b;
  logic [15:0]       err_a, err_b;
  logic [AW:0]       app_a, app_b;
  logic [VEC_W-1:0]  mem_a [DEPTH];
  logic [VEC_W-1:0]  mem_b [DEPTH];

  int checks   = 0;
  int failures = 0;
  int cyc;

  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] s);
    return {s[6:0], ~s};
  endfunction

  assign vec_data_a = mem_a[vec_addr_a];
  assign vec_data_b = mem_b[vec_addr_b];
  assign dut_out_a  = model(dut_in_a);
  always @(posedge clk) begin
    p1_b <= model(dut_in_b);
    p2_b <= p1_b;
  end
  assign dut_out_b = p2_b;

  vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(0)) u_a (
    .clk(clk), .reset_n(rst_a_n), .start(start_a), .vec_addr(vec_addr_a),
    .vec_data(vec_data_a), .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_idx(fei_a),
    .first_err_valid(fev_a), .applied_count(app_a));

  vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(2)) u_b (
    .clk(clk), .reset_n(rst_b_n), .start(start_b), .vec_addr(vec_addr_b),
    .vec_data(vec_data_b), .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(fei_b),
    .first_err_valid(fev_b), .applied_count(app_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Fill a store: n valid vectors, exp bit 5 flipped at bad0/bad1, mask bit 5 kept iff m5.
  task automatic load(input bit b, input int n, input int bad0, input int bad1, input bit m5);
    logic [IN_W-1:0]  s;
    logic [OUT_W-1:0] e, m;
    for (int i = 0; i < int'(DEPTH); i++) begin
      s = IN_W'(i * 37 + 5);
      e = model(s);
      if (i == bad0 || i == bad1) e[5] = ~e[5];
      m = '1;
      m[5] = m5;
      if (b) mem_b[i] = (i < n) ? {1'b1, s, e, m} : '0;
      else   mem_a[i] = (i < n) ? {1'b1, s, e, m} : '0;
    end
  endtask

  task automatic set_start(input bit b, input logic v);
    if (b) start_b = v;
    else   start_a = v;
  endtask

  // Pulse start, return cycles from the start edge until done; optionally re-pulse start at cycle poke.
  task automatic run(input bit b, input int poke, output int cycles);
    @(negedge clk);
    set_start(b, 1'b1);
    @(posedge clk);
    #1 set_start(b, 1'b0);
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      set_start(b, cycles == poke);
      if (b ? done_b : done_a) break;
    end
    set_start(b, 1'b0);
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    load(0, 0, -1, -1, 1'b1);
    load(1, 0, -1, -1, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_app", 32'(app_a), 32'd0);
    chk("rst_dut_in", 32'(dut_in_b), 32'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // Terminator at word 0
    run(0, -1, cyc);
    chk("empty_cycles", 32'(cyc), 32'd3);
    chk("empty_app", 32'(app_a), 32'd0);
    chk("empty_dut_in", 32'(dut_in_a), 32'd0);
    chk("empty_pass", 32'(pass_a), 32'd1);

    // Four matching vectors
    load(0, 4, -1, -1, 1'b1);
    run(0, -1, cyc);
    chk("t1_cycles", 32'(cyc), 32'd7);
    chk("t1_pass", 32'(pass_a), 32'd1);
    chk("t1_err", 32'(err_a), 32'd0);
    chk("t1_app", 32'(app_a), 32'd4);
    chk("t1_addr", 32'(vec_addr_a), 32'd4);
    chk("t1_busy", 32'(busy_a), 32'd0);
    chk("t1_dut_in", 32'(dut_in_a), 32'(12'(3 * 37 + 5)));

    // Vector 3 of 6 wrong, bit checked
    load(0, 6, 3, -1, 1'b1);
    run(0, -1, cyc);
    chk("t2_cycles", 32'(cyc), 32'd9);
    chk("t2_err", 32'(err_a), 32'd1);
    chk("t2_fei", 32'(fei_a), 32'd3);
    chk("t2_fev", 32'(fev_a), 32'd1);
    chk("t2_pass", 32'(pass_a), 32'd0);

    // Same wrong bit, masked out
    load(0, 6, 3, -1, 1'b0);
    run(0, -1, cyc);
    chk("t3_pass", 32'(pass_a), 32'd1);
    chk("t3_err", 32'(err_a), 32'd0);
    chk("t3_fev", 32'(fev_a), 32'd0);

    // LAT=2, full store, vectors 7 and 20 wrong
    load(1, 32, 7, 20, 1'b1);
    run(1, -1, cyc);
    chk("t5_cycles", 32'(cyc), 32'd37);
    chk("t5_addr", 32'(vec_addr_b), 32'd31);
    chk("t5_app", 32'(app_b), 32'd32);
    chk("t5_err", 32'(err_b), 32'd2);
    chk("t5_fei", 32'(fei_b), 32'd7);
    chk("t5_pass", 32'(pass_b), 32'd0);

    // Reset mid-RUN
    load(0, 6, -1, -1, 1'b1);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_a_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy_a), 32'd0);
    chk("mid_app", 32'(app_a), 32'd0);
    chk("mid_addr", 32'(vec_addr_a), 32'd0);
    chk("mid_dut_in", 32'(dut_in_a), 32'd0);
    chk("mid_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst_a_n = 1'b1;

    // Fresh run with start pulsed while in DRAIN
    run(0, 7, cyc);
    chk("t6_cycles", 32'(cyc), 32'd9);
    chk("t6_app", 32'(app_a), 32'd6);
    chk("t6_pass", 32'(pass_a), 32'd1);
    repeat (3) @(negedge clk);
    chk("t6_hold_done", 32'(done_a), 32'd1);
    chk("t6_hold_busy", 32'(busy_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
